// File: rtl/reg_arb_pkg.sv
// Shared types and the rotating-priority pick used by the register load arbiter.
// Supports up to MAX_REQ requesters; callers pass their actual count.
package reg_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set request at or above ptr, wrapping from nreq-1 back to 0.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [IDX_W-1:0]   ptr,
                                    input int                 nreq);
    pick_t r;
    int    idx;
    r = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = ({29'd0, ptr} + k) % nreq;
      if (k < nreq && !r.found && req[idx[IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = idx[IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_load_arbiter_load_reg.sv
// Shared data register: async active-low clear, synchronous load enable.
module load_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter that loads one requester's word into a shared register,
// then holds it for HOLD_CYCLES guard cycles before accepting another load.
module reg_load_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data,
  output logic [NREQ-1:0]         grant,
  output logic [WIDTH-1:0]        Q,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic                    valid
);

  import reg_arb_pkg::*;

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [OW-1:0]   ptr_reg, ptr_next;
  logic [OW-1:0]   owner_reg, owner_next;
  logic [NREQ-1:0] grant_reg, grant_next;
  logic            busy_reg, busy_next;
  logic            valid_reg, valid_next;
  logic            load_en;

  logic [WIDTH-1:0]   word [NREQ];
  logic [MAX_REQ-1:0] req_wide;
  pick_t              pick;
  logic [OW-1:0]      win;
  logic [OW-1:0]      ptr_inc;
  logic [WIDTH-1:0]   load_word;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
      assign word[gi] = data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign req_wide  = MAX_REQ'(req);
  assign pick      = rr_pick(req_wide, IDX_W'(ptr_reg), NREQ);
  assign win       = pick.idx[OW-1:0];
  assign ptr_inc   = (win == OW'(NREQ - 1)) ? '0 : win + 1'b1;
  assign load_word = word[win];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    valid_next = valid_reg;
    grant_next = '0;
    load_en    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick.found) begin
          load_en    = 1'b1;
          grant_next = NREQ'(1) << win;
          owner_next = win;
          valid_next = 1'b1;
          ptr_next   = ptr_inc;
          cnt_next   = CW'(HOLD_CYCLES);
          state_next = HOLD;
        end
      end
      HOLD: begin
        // Requests seen here are deliberately ignored; they stay pending.
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CW'(1)) begin
          state_next = IDLE;
        end
      end
    endcase
    busy_next = (state_next == HOLD);
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ptr_reg   <= '0;
      owner_reg <= '0;
      grant_reg <= '0;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      grant_reg <= grant_next;
      busy_reg  <= busy_next;
      valid_reg <= valid_next;
    end
  end

  load_reg #(.WIDTH(WIDTH)) u_q (
    .clk   (Clk),
    .rst_n (reset),
    .load  (load_en),
    .d     (load_word),
    .q     (Q)
  );

  assign grant = grant_reg;
  assign owner = owner_reg;
  assign busy  = busy_reg;
  assign valid = valid_reg;

endmodule

// File: doc/reg_load_arbiter.md
# reg_load_arbiter

Round-robin load arbiter for a shared WIDTH-bit register. NREQ requesters each present a data word and a request; the block picks one winner, loads the register with the winner's word, pulses that requester's grant, and holds the register stable for a fixed guard interval before the next load. It is the sequencing and sharing front end for the 4-bit load-register datapath.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8.
- WIDTH, 4: register and data width.
- HOLD_CYCLES, 2: guard cycles after each load; must be ≥1.

Ports:
- Clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  request per requester; level-sensitive.
- data  in  NREQ*WIDTH  requester i's word is in data[i*WIDTH +: WIDTH].
- grant  out  NREQ  one-hot, one-cycle pulse to the requester whose word was just loaded.
- Q  out  WIDTH  shared register contents.
- owner  out  $clog2(NREQ)  index of the last granted requester.
- busy  out  1  high while in HOLD, i.e. no load possible.
- valid  out  1  high once any load has occurred since reset.

## Operation
- Reset values: Q=0, grant=0, owner=0, busy=0, valid=0, state=IDLE, ptr=0, cnt=0.
- Two-state FSM:
  - IDLE: at an edge with req≠0, pick winner w and perform the load. Then go to HOLD with cnt=HOLD_CYCLES.
  - HOLD: decrement cnt each edge. At the edge where cnt==1, return to IDLE.
- A load does all of the following: Q←data[w], grant←onehot(w), owner←w, valid←1, ptr←(w+1) mod NREQ.
- Winner selection: the first set bit of req, searching from ptr upward and wrapping past NREQ-1 to 0. After reset, priority starts at requester 0.
- Handshake:
  - A requester holds req high with stable data until it sees its grant.
  - It drops req in the grant cycle.
  - req and data sampled during HOLD are ignored.
- No requests: Q, owner and valid hold indefinitely; changes on data have no effect.
- A requester re-asserting req immediately after its grant goes to the back of the rotation.
- Reset mid-HOLD: reset acts immediately, asynchronously. All outputs and state return to reset values; a pending grant pulse is lost.

## Timing
- Load latency: req seen high in IDLE at edge t → Q, owner and grant updated at edge t. Q is visible in the cycle after edge t.
- grant is high for exactly the single cycle following the load edge.
- busy is high for HOLD_CYCLES cycles after the load edge.
- Minimum spacing between loads is HOLD_CYCLES+1 cycles. Q is guaranteed stable for at least that long after each load.
- Under continuous all-requester contention, each requester is granted once every NREQ*(HOLD_CYCLES+1) cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package reg_arb_pkg holds:
  - the FSM state enum {IDLE, HOLD};
  - a rotate-priority pick function returning winner index and found flag.
- Sub-module load_reg(WIDTH): a register with async active-low reset and synchronous load enable, driving Q. The arbiter drives its load and D inputs.

## Test plan
All scenarios use NREQ=4, WIDTH=4, HOLD_CYCLES=2.
- Reset: hold reset=0 for 3 cycles with req=1111 → Q=0, grant=0000, owner=0, busy=0, valid=0 throughout.
- Single request: req=0010 with data[1]=0xA → after the next edge, Q=0xA, grant=0010 for 1 cycle, owner=1, busy=1 for 2 cycles, valid=1.
- Full contention: all requesters assert, data[i]=i+5, each drops req on its grant → grants in order 0001, 0010, 0100, 1000, spaced 3 cycles apart, with Q=5, 6, 7, 8.
- Wrap-around: after requester 2 is granted (ptr=3), assert req=1001 → requester 3 is granted first, then requester 0 three cycles later.
- Reset mid-HOLD: assert reset=0 one cycle after a load of 0xC → Q=0 and busy=0 immediately. After release, a held req=0100 is granted at the first edge and Q=data[2].
- Idle hold: after loading 0x3, keep req=0 for 20 cycles while toggling all data → Q stays 0x3, grant stays 0000.
